control_unit_mc: RTL

- Parametrised multicycle control FSM for the RV64 datapath; next generation of the current control unit.
- Adds a synchronous reset, variable memory latency via wait-state counting, and standard RV64I encodings (sd = funct3 011; all branches under opcode 1100011).
- Adds trap handling for illegal instructions and signed add/sub/addi overflow, with EPC load and a cause register.
- Outputs are Moore-decoded from the state register and the wait counter; sits between the instruction register and the datapath.

---
 rtl/control_unit_mc.sv | 139 +++++++++++++
 1 files changed

// File: rtl/control_unit_mc.sv
// control_unit_mc: multicycle RV64 control FSM with memory wait states and trap handling.
module control_unit_mc #(
  parameter int MEM_LATENCY = 0,
  parameter bit EXC_ENABLE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        overflow,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        ALUSrcA,
  output logic        LoadRegA,
  output logic        LoadRegB,
  output logic        LoadALUOut,
  output logic        WriteReg,
  output logic        LoadIR,
  output logic        IMemWrite,
  output logic        DMemWrite,
  output logic        LoadMDR,
  output logic        LoadEPC,
  output logic [1:0]  PCSrc,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUFunct,
  output logic [2:0]  MemToReg,
  output logic [1:0]  BranchOp,
  output logic [1:0]  tam,
  output logic [1:0]  ShiftControl,
  output logic [1:0]  ExcCause,
  output logic [4:0]  state
);
  localparam logic [4:0] S_FETCH  = 5'd0,  S_DECODE = 5'd1,  S_ADDR   = 5'd2,  S_MEM_RD = 5'd3,
                         S_LD_WB  = 5'd4,  S_MEM_WR = 5'd5,  S_ALU_R  = 5'd6,  S_ALU_I  = 5'd7,
                         S_ALU_WB = 5'd8,  S_SHIFT  = 5'd9,  S_LUI    = 5'd10, S_BRANCH = 5'd11,
                         S_BR_WAIT = 5'd12, S_EXC   = 5'd13;

  logic [4:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] cause_q, cause_d;

  logic [6:0] op, f7;
  logic [5:0] f6;
  logic [2:0] f3;
  logic       fin, mem_st, is_r, is_i, is_sh, is_ld, is_st, is_lui, is_br, legal, addsub;
  logic       unused_bits;

  assign op = instruction[6:0];
  assign f3 = instruction[14:12];
  assign f7 = instruction[31:25];
  assign f6 = instruction[31:26];
  assign unused_bits = ^{instruction[24:15], instruction[11:7]};

  assign is_r   = op == 7'b0110011 && ((f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b111)) ||
                                       (f7 == 7'b0100000 && f3 == 3'b000));
  assign is_i   = op == 7'b0010011 && f3 == 3'b000;
  assign is_sh  = op == 7'b0010011 && ((f3 == 3'b001 && f6 == 6'b000000) ||
                                       (f3 == 3'b101 && (f6 == 6'b000000 || f6 == 6'b010000)));
  assign is_ld  = op == 7'b0000011 && !f3[2];
  assign is_st  = op == 7'b0100011 && !f3[2];
  assign is_lui = op == 7'b0110111;
  assign is_br  = op == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101);
  assign legal  = is_r || is_i || is_sh || is_ld || is_st || is_lui || is_br;
  assign addsub = f3 == 3'b000;

  assign fin    = cnt_q == 3'(MEM_LATENCY);
  assign mem_st = state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR;
  assign cnt_d  = (mem_st && !fin) ? cnt_q + 3'd1 : 3'd0;

  always_comb begin
    state_d = S_FETCH;
    cause_d = cause_q;
    case (state_q)
      S_FETCH:  state_d = fin ? S_DECODE : S_FETCH;
      S_DECODE: begin
        state_d = is_r ? S_ALU_R : is_i ? S_ALU_I : is_sh ? S_SHIFT : (is_ld || is_st) ? S_ADDR :
                  is_lui ? S_LUI : is_br ? S_BRANCH : EXC_ENABLE ? S_EXC : S_FETCH;
        cause_d = (!legal && EXC_ENABLE) ? 2'b01 : cause_q;
      end
      S_ADDR:   state_d = is_ld ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: state_d = fin ? S_LD_WB : S_MEM_RD;
      S_MEM_WR: state_d = fin ? S_FETCH : S_MEM_WR;
      S_ALU_R: begin
        state_d = (addsub && overflow && EXC_ENABLE) ? S_EXC : S_ALU_WB;
        cause_d = (addsub && overflow && EXC_ENABLE) ? 2'b10 : cause_q;
      end
      S_ALU_I: begin
        state_d = (overflow && EXC_ENABLE) ? S_EXC : S_ALU_WB;
        cause_d = (overflow && EXC_ENABLE) ? 2'b10 : cause_q;
      end
      S_BRANCH: state_d = S_BR_WAIT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 3'd0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Moore outputs; everything is forced low while reset is asserted.
  always_comb begin
    PCWrite = 1'b0; PCWriteCond = 1'b0; ALUSrcA = 1'b0; LoadRegA = 1'b0; LoadRegB = 1'b0;
    LoadALUOut = 1'b0; WriteReg = 1'b0; LoadIR = 1'b0; DMemWrite = 1'b0; LoadMDR = 1'b0;
    LoadEPC = 1'b0; PCSrc = 2'b00; ALUSrcB = 2'b00; ALUFunct = 3'b000; MemToReg = 3'b000;
    BranchOp = 2'b00; tam = 2'b00; ShiftControl = 2'b00;
    if (!reset) begin
      case (state_q)
        S_FETCH:  begin ALUSrcB = 2'b01; ALUFunct = 3'b001; PCWrite = fin; LoadIR = fin; end
        S_DECODE: begin LoadRegA = 1'b1; LoadRegB = 1'b1; ALUSrcB = 2'b11; ALUFunct = 3'b001; LoadALUOut = 1'b1; end
        S_ADDR:   begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUFunct = 3'b001; LoadALUOut = 1'b1; end
        S_MEM_RD: begin tam = ~f3[1:0]; LoadMDR = fin; end
        S_LD_WB:  begin WriteReg = 1'b1; MemToReg = 3'b001; tam = ~f3[1:0]; end
        S_MEM_WR: begin DMemWrite = 1'b1; tam = ~f3[1:0]; end
        S_ALU_R:  begin ALUSrcA = 1'b1; LoadALUOut = 1'b1;
                        ALUFunct = (f3 == 3'b111) ? 3'b011 : f7[5] ? 3'b010 : 3'b001; end
        S_ALU_I:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUFunct = 3'b001; LoadALUOut = 1'b1; end
        S_ALU_WB: WriteReg = 1'b1;
        S_SHIFT:  begin WriteReg = 1'b1; MemToReg = 3'b100;
                        ShiftControl = (f3 == 3'b001) ? 2'b00 : instruction[30] ? 2'b10 : 2'b01; end
        S_LUI:    begin WriteReg = 1'b1; MemToReg = 3'b010; end
        S_BRANCH: begin ALUSrcA = 1'b1; ALUFunct = 3'b010; PCWriteCond = 1'b1; PCSrc = 2'b01;
                        BranchOp = {f3[2], f3[2] ^ f3[0]}; end
        S_EXC:    begin LoadEPC = 1'b1; PCWrite = 1'b1; PCSrc = 2'b10; end
        default:  ;
      endcase
    end
  end

  assign IMemWrite = 1'b0;
  assign ExcCause  = reset ? 2'b00 : cause_q;
  assign state     = state_q;
endmodule
